// File: rtl/mdu_seq_if.sv
// Handshake and operand/result bus between the control unit and the
// sequential multiply/divide unit.
interface mdu_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op_mul;
   logic             op_div;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] Chigh;
   logic [WIDTH-1:0] Clow;

   // control unit side
   modport master (
      output start, op_mul, op_div, A, B,
      input  busy, done, div_by_zero, Chigh, Clow
   );

   // multiply/divide unit side
   modport slave (
      input  start, op_mul, op_div, A, B,
      output busy, done, div_by_zero, Chigh, Clow
   );
endinterface

// File: rtl/mdu_seq.sv
// Sequential signed multiply/divide unit.
// MUL: radix-4 Booth, one bit-pair per cycle (WIDTH/2 cycles).
// DIV: non-restoring, one bit per cycle (WIDTH cycles) plus a sign-fix cycle.
// Results land in the registered Chigh/Clow pair one cycle after DONE is
// entered, together with the done pulse.
module mdu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic      clock,
   input  logic      clear,
   mdu_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH/2 - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

   state_t state, state_nx;

   // Shared working registers:
   //   MUL: hi = Booth accumulator (WIDTH+2, sign-extended), lo = multiplier
   //        shifting out low pairs / product low half, m = multiplicand.
   //   DIV: hi[WIDTH:0] = signed remainder R, lo = Q, m = |B|.
   logic [WIDTH+1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] m;
   logic             qm1;       // B[2i-1] for the next Booth triplet
   logic             sgn_a;
   logic             sgn_b;
   logic             dz_pend;   // divide-by-zero seen, reported at done
   logic [CNT_W-1:0] cnt;

   logic             busy_q;
   logic             done_q;
   logic             dz_q;
   logic [WIDTH-1:0] chigh_q;
   logic [WIDTH-1:0] clow_q;

   // FSM control strobes
   logic ld_mul, ld_div, ld_dz;
   logic step_mul, step_div, do_fix, do_done;

   // Operand magnitudes; |most-negative| = 2^(WIDTH-1) still fits unsigned.
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             b_zero;

   assign a_mag  = bus.A[WIDTH-1] ? -bus.A : bus.A;
   assign b_mag  = bus.B[WIDTH-1] ? -bus.B : bus.B;
   assign b_zero = (bus.B == '0);

   // Booth digit selection and partial-sum add
   logic [2:0]       booth_sel;
   logic [WIDTH+1:0] m_ext, booth_add, booth_sum;

   always_comb begin
      booth_sel = {lo[1:0], qm1};
      m_ext     = {{2{m[WIDTH-1]}}, m};
      booth_add = '0;
      case (booth_sel)
         3'b001, 3'b010: booth_add = m_ext;
         3'b011:         booth_add = m_ext << 1;
         3'b100:         booth_add = -(m_ext << 1);
         3'b101, 3'b110: booth_add = -m_ext;
         default:        booth_add = '0;
      endcase
      booth_sum = hi + booth_add;
   end

   // Non-restoring step and final sign correction
   logic [WIDTH:0]   d_ext, r_sh, r_step, r_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   always_comb begin
      d_ext   = {1'b0, m};
      r_sh    = {hi[WIDTH-1:0], lo[WIDTH-1]};
      r_step  = hi[WIDTH] ? (r_sh + d_ext) : (r_sh - d_ext);
      r_fix   = hi[WIDTH] ? (hi[WIDTH:0] + d_ext) : hi[WIDTH:0];
      quo_fix = (sgn_a ^ sgn_b) ? -lo : lo;
      rem_fix = sgn_a ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
   end

   // State register
   always_ff @(posedge clock) begin
      if (clear) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state and control strobes
   always_comb begin
      state_nx = state;
      ld_mul   = 1'b0;
      ld_div   = 1'b0;
      ld_dz    = 1'b0;
      step_mul = 1'b0;
      step_div = 1'b0;
      do_fix   = 1'b0;
      do_done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start && bus.op_mul) begin
               ld_mul   = 1'b1;
               state_nx = S_MUL;
            end else if (bus.start && bus.op_div) begin
               if (b_zero) begin
                  ld_dz    = 1'b1;
                  state_nx = S_DONE;
               end else begin
                  ld_div   = 1'b1;
                  state_nx = S_DIV;
               end
            end
         end
         S_MUL: begin
            step_mul = 1'b1;
            if (cnt == MUL_LAST) state_nx = S_DONE;
         end
         S_DIV: begin
            step_div = 1'b1;
            if (cnt == DIV_LAST) state_nx = S_FIX;
         end
         S_FIX: begin
            do_fix   = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            do_done  = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: operand latch, Booth/non-restoring iteration, sign fix
   always_ff @(posedge clock) begin
      if (clear) begin
         hi      <= '0;
         lo      <= '0;
         m       <= '0;
         qm1     <= 1'b0;
         sgn_a   <= 1'b0;
         sgn_b   <= 1'b0;
         dz_pend <= 1'b0;
         cnt     <= '0;
      end else if (ld_mul) begin
         hi      <= '0;
         lo      <= bus.B;
         m       <= bus.A;
         qm1     <= 1'b0;
         dz_pend <= 1'b0;
         cnt     <= '0;
      end else if (ld_div) begin
         hi      <= '0;
         lo      <= a_mag;
         m       <= b_mag;
         sgn_a   <= bus.A[WIDTH-1];
         sgn_b   <= bus.B[WIDTH-1];
         dz_pend <= 1'b0;
         cnt     <= '0;
      end else if (ld_dz) begin
         // Division by zero: remainder slot carries A, quotient all ones
         hi      <= {2'b00, bus.A};
         lo      <= '1;
         dz_pend <= 1'b1;
         cnt     <= '0;
      end else if (step_mul) begin
         // add the recoded digit, then arithmetic shift {hi,lo} right by 2
         hi  <= {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
         lo  <= {booth_sum[1:0], lo[WIDTH-1:2]};
         qm1 <= lo[1];
         cnt <= cnt + 1'b1;
      end else if (step_div) begin
         hi  <= {r_step[WIDTH], r_step};
         lo  <= {lo[WIDTH-2:0], ~r_step[WIDTH]};
         cnt <= cnt + 1'b1;
      end else if (do_fix) begin
         hi <= {2'b00, rem_fix};
         lo <= quo_fix;
      end
   end

   // Registered outputs: results and done/flag update on leaving DONE
   always_ff @(posedge clock) begin
      if (clear) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         chigh_q <= '0;
         clow_q  <= '0;
      end else begin
         busy_q <= (state_nx != S_IDLE);
         done_q <= do_done;
         if (ld_mul || ld_div || ld_dz) dz_q <= 1'b0;
         if (do_done) begin
            chigh_q <= hi[WIDTH-1:0];
            clow_q  <= lo;
            dz_q    <= dz_pend;
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dz_q;
   assign bus.Chigh       = chigh_q;
   assign bus.Clow        = clow_q;

endmodule
